uart_frame_decoder: RTL

UART_FRAME_DECODER -- requirements
Module: uart_frame_decoder

---
 rtl/uart_frame_decoder_pkg.sv | 19 +
 rtl/uart_frame_decoder_buffer.sv | 24 ++
 rtl/uart_frame_decoder.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/uart_frame_decoder_pkg.sv
// Shared definitions for the UART frame decoder: FSM states, error codes and the default SOF marker.
package uart_frame_decoder_pkg;

   typedef enum logic [2:0] {
      ST_HUNT,
      ST_LEN,
      ST_PAYLOAD,
      ST_CHECK,
      ST_DRAIN
   } state_t;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_LEN     = 2'b01;
   localparam logic [1:0] ERR_CHK     = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT = 2'b11;

   localparam logic [7:0] SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_frame_decoder_buffer.sv
// Payload store for the frame decoder: simple dual-port RAM with registered, enabled read (EBR-style, no reset).
module uart_frame_buffer #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [7:0]    wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data
);

   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_addr] <= wr_data;
      if (rd_en)
         rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/uart_frame_decoder.sv
// UART frame decoder: SOF, LEN, payload, CHK framing with buffered drain to a ready/valid consumer.
// Optional mid-frame inter-byte timeout enabled by defining UART_FRAME_TIMEOUT_EN.
module uart_frame_decoder
   import uart_frame_decoder_pkg::*;
#(
   parameter int unsigned MAX_PAYLOAD    = 16,
   parameter logic [7:0]  SOF_BYTE       = SOF_DEFAULT,
   parameter int unsigned TIMEOUT_CYCLES = 48_000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] data_in,
   input  logic       data_valid,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_last,
   output logic       frame_ok,
   output logic       frame_error,
   output logic [1:0] err_code,
   output logic       overrun
);

   localparam int unsigned IW      = $clog2(MAX_PAYLOAD + 1);
   localparam int unsigned AW      = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
   localparam logic [7:0]  MAX_LEN = 8'(MAX_PAYLOAD);

   state_t          state;
   logic [IW-1:0]   len;
   logic [IW-1:0]   wr_idx;
   logic [IW-1:0]   rd_idx;
   logic [7:0]      chk;
   logic            expired;
   logic            wr_en;
   logic            rd_en;
   logic [AW-1:0]   rd_addr;
   logic [7:0]      rd_data;

   // Read port prefetches entry 0 while the CHK byte is accepted, then the next entry on each handshake.
   assign wr_en   = (state == ST_PAYLOAD) && data_valid;
   assign rd_en   = ((state == ST_CHECK) && data_valid) ||
                    ((state == ST_DRAIN) && out_ready && !out_last);
   assign rd_addr = (state == ST_DRAIN) ? AW'(rd_idx + IW'(1)) : '0;

   uart_frame_buffer #(
      .DEPTH (MAX_PAYLOAD),
      .AW    (AW)
   ) u_buffer (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (AW'(wr_idx)),
      .wr_data (data_in),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   assign out_data = out_valid ? rd_data : '0;

`ifdef UART_FRAME_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] timer;
   logic          in_frame;

   assign in_frame = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CHECK);
   assign expired  = in_frame && !data_valid && (timer == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (!reset_n || !in_frame || data_valid || expired)
         timer <= '0;
      else
         timer <= timer + TW'(1);
   end
`else
   assign expired = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= ST_HUNT;
         len         <= '0;
         wr_idx      <= '0;
         rd_idx      <= '0;
         chk         <= '0;
         out_valid   <= 1'b0;
         out_last    <= 1'b0;
         frame_ok    <= 1'b0;
         frame_error <= 1'b0;
         overrun     <= 1'b0;
         err_code    <= ERR_NONE;
      end else begin
         frame_ok    <= 1'b0;
         frame_error <= 1'b0;
         overrun     <= 1'b0;
         if (expired) begin
            frame_error <= 1'b1;
            err_code    <= ERR_TIMEOUT;
            wr_idx      <= '0;
            state       <= ST_HUNT;
         end else begin
            case (state)
               ST_HUNT: begin
                  if (data_valid && (data_in == SOF_BYTE))
                     state <= ST_LEN;
               end
               ST_LEN: begin
                  if (data_valid) begin
                     if ((data_in == 8'd0) || (data_in > MAX_LEN)) begin
                        frame_error <= 1'b1;
                        err_code    <= ERR_LEN;
                        state       <= ST_HUNT;
                     end else begin
                        len    <= data_in[IW-1:0];
                        chk    <= data_in;
                        wr_idx <= '0;
                        state  <= ST_PAYLOAD;
                     end
                  end
               end
               ST_PAYLOAD: begin
                  if (data_valid) begin
                     chk <= chk + data_in;
                     if (wr_idx == len - IW'(1)) begin
                        wr_idx <= '0;
                        state  <= ST_CHECK;
                     end else begin
                        wr_idx <= wr_idx + IW'(1);
                     end
                  end
               end
               ST_CHECK: begin
                  if (data_valid) begin
                     if (data_in == chk) begin
                        frame_ok  <= 1'b1;
                        out_valid <= 1'b1;
                        out_last  <= (len == IW'(1));
                        rd_idx    <= '0;
                        state     <= ST_DRAIN;
                     end else begin
                        frame_error <= 1'b1;
                        err_code    <= ERR_CHK;
                        state       <= ST_HUNT;
                     end
                  end
               end
               ST_DRAIN: begin
                  overrun <= data_valid;
                  if (out_ready) begin
                     if (out_last) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        state     <= ST_HUNT;
                     end else begin
                        rd_idx   <= rd_idx + IW'(1);
                        out_last <= (rd_idx + IW'(1) == len - IW'(1));
                     end
                  end
               end
               default: state <= ST_HUNT;
            endcase
         end
      end
   end

endmodule
